// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the VGA raster timing generator: default 640x480@60
// timing, coordinate width and the prefetch FSM state type.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    PF_IDLE = 1'b0,
    PF_REQ  = 1'b1
  } pf_state_t;

  // True when pos lies in the half-open band [lo, lo+len).
  function automatic logic in_band(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing and line-prefetch signal bundle between the timing generator
// (master) and the pixel pipeline / memory side (slave).
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic               pixEn;
  logic               hSync;
  logic               vSync;
  logic               displayActive;
  logic               fetchActive;
  logic [COORD_W-1:0] column;
  logic [COORD_W-1:0] row;
  logic               frameStart;
  logic               lineReq;
  logic [COORD_W-1:0] lineRow;
  logic               lineAck;
  logic               lineMiss;

  modport master (
    input  pixEn, lineAck,
    output hSync, vSync, displayActive, fetchActive, column, row,
           frameStart, lineReq, lineRow, lineMiss
  );

  modport slave (
    output pixEn, lineAck,
    input  hSync, vSync, displayActive, fetchActive, column, row,
           frameStart, lineReq, lineRow, lineMiss
  );

endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// Pixel-enable qualified shift register that delays the late timing signals
// by a fixed number of pixel periods; depth 0 is a plain wire.
module vga_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = clk ^ rst ^ en;
      assign q = d;
    end else begin : g_line
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with early coordinates and an
// optional line-prefetch handshake (build with VGA_TIMING_PREFETCH_EN).
//
// Prefetch FSM states:
//   state   | meaning
//   PF_IDLE | no request outstanding
//   PF_REQ  | lineReq high for lineRow, waiting for lineAck or line wrap
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int LEAD     = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic POL = (SYNC_POL != 0);
  localparam logic [2:0] SYNC_IDLE = {~POL, ~POL, 1'b0};

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || LEAD < 0 || LEAD > 15) begin : g_bad_cfg
      $error("vga_timing_gen: totals must be <= 1024 and LEAD within 0..15");
    end
  endgenerate

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_last, v_last;

  assign h_last = (int'(h_cnt) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt) == V_TOTAL - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (bus.pixEn) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + COORD_W'(1);
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  logic vis, hs_lvl, vs_lvl;

  assign vis    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs_lvl = in_band(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC) ? POL : ~POL;
  assign vs_lvl = in_band(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC) ? POL : ~POL;

  // Early stage: coordinates and fetchActive, plus the first sync stage that
  // the delay line then retards by LEAD pixels.
  logic               fetch_q, frame_start_q;
  logic [COORD_W-1:0] column_q, row_q;
  logic [2:0]         sync_q, sync_late;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_q       <= 1'b0;
      column_q      <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
      sync_q        <= SYNC_IDLE;
    end else begin
      frame_start_q <= bus.pixEn && (h_cnt == '0) && (v_cnt == '0);
      if (bus.pixEn) begin
        fetch_q  <= vis;
        column_q <= vis ? h_cnt : '0;
        row_q    <= vis ? v_cnt : '0;
        sync_q   <= {hs_lvl, vs_lvl, vis};
      end
    end
  end

  vga_delay_line #(
    .DEPTH   (LEAD),
    .WIDTH   (3),
    .RST_VAL (SYNC_IDLE)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (bus.pixEn),
    .d   (sync_q),
    .q   (sync_late)
  );

  assign bus.hSync         = sync_late[2];
  assign bus.vSync         = sync_late[1];
  assign bus.displayActive = sync_late[0];
  assign bus.fetchActive   = fetch_q;
  assign bus.column        = column_q;
  assign bus.row           = row_q;
  assign bus.frameStart    = frame_start_q;

`ifdef VGA_TIMING_PREFETCH_EN
  pf_state_t          state_q, state_d;
  logic               miss_q, miss_d;
  logic [COORD_W-1:0] line_row_q, next_row;
  logic               next_vis, trigger;

  // The last line of the frame requests row 0 of the next frame.
  assign next_vis = v_last || (int'(v_cnt) + 1 < V_ACTIVE);
  assign next_row = v_last ? '0 : v_cnt + COORD_W'(1);
  assign trigger  = bus.pixEn && (int'(h_cnt) == H_ACTIVE) && next_vis;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PF_IDLE;
      miss_q     <= 1'b0;
      line_row_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (state_q == PF_IDLE && trigger) line_row_q <= next_row;
    end
  end

  always_comb begin
    state_d = state_q;
    miss_d  = 1'b0;
    case (state_q)
      PF_IDLE: if (trigger) state_d = PF_REQ;
      PF_REQ: begin
        if (bus.lineAck) begin
          state_d = PF_IDLE;
        end else if (bus.pixEn && h_last) begin
          state_d = PF_IDLE;
          miss_d  = 1'b1;
        end
      end
      default: state_d = PF_IDLE;
    endcase
  end

  assign bus.lineReq  = (state_q == PF_REQ);
  assign bus.lineMiss = miss_q;
  assign bus.lineRow  = line_row_q;
`else
  logic unused_ack;
  assign unused_ack   = bus.lineAck;
  assign bus.lineReq  = 1'b0;
  assign bus.lineMiss = 1'b0;
  assign bus.lineRow  = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: small raster, SYNC_POL=1, LEAD=3,
// randomized pixEn/lineAck against a position-arithmetic reference model.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int POL = 1, LD = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef VGA_TIMING_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (POL), .LEAD (LD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = pixEn advances since reset; counters sit at position k,
  // early outputs show position k-1, late outputs position k-1-LD.
  int k = 0;
  bit m_req = 0, m_miss = 0, fs_exp = 0;
  int m_row = 0;
  bit r_s, pe_s, ack_s;
  int h_now, v_now, qe, he, ve, qd, hd, vd;
  bit e_fetch, e_da, e_hs, e_vs;

  always @(posedge clk) begin
    r_s   = rst;
    pe_s  = vif.pixEn;
    ack_s = vif.lineAck;
    h_now = k % HT;
    v_now = (k / HT) % VT;
    fs_exp = 0;
    if (!r_s) begin
      k = 0; m_req = 0; m_miss = 0; m_row = 0;
    end else begin
      m_miss = 0;
      if (m_req) begin
        if (ack_s) m_req = 0;
        else if (pe_s && h_now == HT - 1) begin m_req = 0; m_miss = 1; end
      end else if (PF && pe_s && h_now == HA && (v_now == VT - 1 || v_now + 1 < VA)) begin
        m_req = 1;
        m_row = (v_now == VT - 1) ? 0 : v_now + 1;
      end
      if (pe_s) begin
        fs_exp = (k % FRAME) == 0;
        k++;
      end
    end
    #1;
    qe = k - 1;
    he = (qe >= 0) ? qe % HT : 0;
    ve = (qe >= 0) ? (qe / HT) % VT : 0;
    e_fetch = (qe >= 0) && he < HA && ve < VA;
    qd = k - 1 - LD;
    hd = (qd >= 0) ? qd % HT : 0;
    vd = (qd >= 0) ? (qd / HT) % VT : 0;
    e_da = (qd >= 0) && hd < HA && vd < VA;
    e_hs = ((qd >= 0) && hd >= HA + HF && hd < HA + HF + HS) ? POL[0] : !POL[0];
    e_vs = ((qd >= 0) && vd >= VA + VF && vd < VA + VF + VS) ? POL[0] : !POL[0];
    check("fetchActive",   vif.fetchActive,   e_fetch);
    check("column",        vif.column,        e_fetch ? he : 0);
    check("row",           vif.row,           e_fetch ? ve : 0);
    check("displayActive", vif.displayActive, e_da);
    check("hSync",         vif.hSync,         e_hs);
    check("vSync",         vif.vSync,         e_vs);
    check("frameStart",    vif.frameStart,    fs_exp);
    check("lineReq",       vif.lineReq,       m_req);
    check("lineMiss",      vif.lineMiss,      m_miss);
    check("lineRow",       vif.lineRow,       m_row);
  end

  // lineAck driver: 0 = never, 1 = five clocks after lineReq, 2 = random.
  int ack_mode = 0;
  initial begin
    int age;
    age = 0;
    vif.lineAck = 1'b0;
    forever begin
      @(negedge clk);
      age = vif.lineReq ? age + 1 : 0;
      case (ack_mode)
        1:       vif.lineAck = (age == 5);
        2:       vif.lineAck = ($urandom_range(0, 3) == 0);
        default: vif.lineAck = 1'b0;
      endcase
    end
  end

  initial begin
    int n_da, n_hs, n_vs, n_fs, n_miss;
    vif.pixEn = 1'b0;
    rst = 1'b0;
    repeat (3) begin @(negedge clk); vif.pixEn = 1'($urandom_range(0, 1)); end

    // pixEn every second clock
    @(negedge clk); rst = 1'b1; ack_mode = 1;
    for (int c = 0; c < 400; c++) begin @(negedge clk); vif.pixEn = (c % 2 == 0); end

    // random pixEn and random acks
    ack_mode = 2;
    for (int c = 0; c < 500; c++) begin @(negedge clk); vif.pixEn = ($urandom_range(0, 2) != 0); end

    // mid-frame reset with pixEn held high, then a pause before restarting
    for (int c = 0; c < 57; c++) begin @(negedge clk); vif.pixEn = 1'b1; end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; vif.pixEn = 1'b0;
    repeat (3) @(negedge clk);
    vif.pixEn = 1'b1;
    repeat (60) @(negedge clk);

    // hand-computed frame: continuous pixEn, no acks
    ack_mode = 0;
    @(negedge clk); rst = 1'b0; vif.pixEn = 1'b1;
    @(negedge clk); rst = 1'b1;
    n_da = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_miss = 0;
    for (int j = 1; j <= 110; j++) begin
      @(negedge clk);
      if (j <= 98) begin n_fs += int'(vif.frameStart); n_miss += int'(vif.lineMiss); end
      if (j >= 4 && j <= 101) begin
        n_da += int'(vif.displayActive); n_hs += int'(vif.hSync); n_vs += int'(vif.vSync);
      end
      case (j)
        1:  begin check("lit_fetch_j1", vif.fetchActive, 1); check("lit_col_j1", vif.column, 0);
                  check("lit_fs_j1", vif.frameStart, 1); end
        2:  check("lit_col_j2", vif.column, 1);
        3:  begin check("lit_col_j3", vif.column, 2); check("lit_da_j3", vif.displayActive, 0); end
        4:  check("lit_da_j4", vif.displayActive, 1);
        9:  begin check("lit_req_j9", vif.lineReq, PF); check("lit_row_j9", vif.lineRow, PF ? 1 : 0); end
        13: check("lit_hs_j13", vif.hSync, 0);
        14: begin check("lit_hs_j14", vif.hSync, 1); check("lit_miss_j14", vif.lineMiss, PF); end
        15: begin check("lit_hs_j15", vif.hSync, 1); check("lit_req_j15", vif.lineReq, 0); end
        16: check("lit_hs_j16", vif.hSync, 0);
        73: check("lit_vs_j73", vif.vSync, 0);
        74: check("lit_vs_j74", vif.vSync, 1);
        88: check("lit_vs_j88", vif.vSync, 0);
        93: begin check("lit_req_j93", vif.lineReq, PF); check("lit_row_j93", vif.lineRow, 0); end
        98: check("lit_fs_j98", vif.frameStart, 0);
        99: check("lit_fs_j99", vif.frameStart, 1);
        default: ;
      endcase
    end
    check("lit_da_count", n_da, VA * HA);
    check("lit_hs_count", n_hs, VT * HS);
    check("lit_vs_count", n_vs, HT * VS);
    check("lit_fs_count", n_fs, 1);
    check("lit_miss_count", n_miss, PF ? 4 : 0);

    // acked prefetch with continuous and then random pixEn
    ack_mode = 1;
    repeat (300) @(negedge clk);
    for (int c = 0; c < 300; c++) begin @(negedge clk); vif.pixEn = ($urandom_range(0, 1) != 0); end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
